// File: rtl/chess_pkg.sv
// Shared board constants and types for the move detector.
package chess_pkg;

  localparam int NUM_SQUARES = 64;

  typedef logic [5:0] square_t;

  typedef enum logic [2:0] {
    IDLE,
    LIFTED,
    CAPTURED,
    REPORT,
    ERROR
  } move_state_t;

endpackage

// File: rtl/square_encoder.sv
// Classifies a board difference: exactly one square changed, which one, and
// whether that square became occupied.
module square_encoder
  import chess_pkg::*;
(
  input  logic [NUM_SQUARES-1:0] diff,
  input  logic [NUM_SQUARES-1:0] layout,
  output logic                   single,
  output square_t                idx,
  output logic                   rising
);

  // A power of two has exactly one bit set.
  assign single = (diff != '0) && ((diff & (diff - 64'd1)) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (diff[i]) idx = square_t'(i);
    end
  end

  assign rising = layout[idx];

endmodule

// File: rtl/move_detector.sv
// Debounces scanner frames into a stable board layout and turns successive
// single-square changes into from/to/capture move reports.
module move_detector
  import chess_pkg::*;
#(
  parameter int STABLE_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SQUARES-1:0] chessLayout,
  input  logic                   frame_valid,
  input  logic                   err_clr,
  input  logic                   move_ready,
  output logic [NUM_SQUARES-1:0] stable_layout,
  output logic                   move_valid,
  output square_t                move_from,
  output square_t                move_to,
  output logic                   move_capture,
  output logic                   error
);

  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_FRAMES);

  logic [NUM_SQUARES-1:0] candidate;
  logic [CW-1:0]          count;
  logic                   baseline_done;
  move_state_t            state;
  logic                   commit;
  logic                   single;
  logic                   rising;
  square_t                idx;

  // Commits wait while a report is outstanding; the count just sits saturated.
  assign commit = (count == FULL) && (candidate != stable_layout) && (state != REPORT);

  square_encoder u_enc (
    .diff   (stable_layout ^ candidate),
    .layout (candidate),
    .single (single),
    .idx    (idx),
    .rising (rising)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      candidate <= '0;
      count     <= '0;
    end else if (frame_valid) begin
      if (chessLayout == candidate) begin
        if (count != FULL) count <= count + 1'b1;
      end else begin
        candidate <= chessLayout;
        count     <= CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      stable_layout <= '0;
      baseline_done <= 1'b0;
      move_valid    <= 1'b0;
      move_from     <= '0;
      move_to       <= '0;
      move_capture  <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        REPORT: if (move_ready) begin
          state      <= IDLE;
          move_valid <= 1'b0;
        end
        ERROR: if (err_clr) begin
          state <= IDLE;
          error <= 1'b0;
        end
        default: ;
      endcase

      // The pre-edge candidate is committed, so a frame arriving now only
      // influences a later commit.
      if (commit) begin
        stable_layout <= candidate;
        if (!baseline_done) begin
          baseline_done <= 1'b1;
        end else if (state != ERROR) begin
          if (!single) begin
            state <= ERROR;
            error <= 1'b1;
          end else begin
            case (state)
              IDLE: begin
                if (rising) begin
                  state <= ERROR;
                  error <= 1'b1;
                end else begin
                  move_from <= idx;
                  state     <= LIFTED;
                end
              end
              LIFTED: begin
                if (rising && idx == move_from) begin
                  state <= IDLE;
                end else if (rising) begin
                  move_to      <= idx;
                  move_capture <= 1'b0;
                  move_valid   <= 1'b1;
                  state        <= REPORT;
                end else begin
                  move_to <= idx;
                  state   <= CAPTURED;
                end
              end
              CAPTURED: begin
                if (rising && idx == move_to) begin
                  move_capture <= 1'b1;
                  move_valid   <= 1'b1;
                  state        <= REPORT;
                end else begin
                  state <= ERROR;
                  error <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
